// File: rtl/sha3_digest_reader_if.sv
// Digest word stream between the digest reader (master) and its consumer (slave).
interface sha3_digest_reader_if;
   logic        valid;
   logic        ready;
   logic [63:0] data;
   logic        last;

   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/sha3_digest_reader.sv
// Streams the squeezed Keccak state out as 64-bit digest words, requesting a
// further permutation each time the rate is exhausted before the length is met.
module sha3_digest_reader #(
   parameter bit EnMasking = 1'b0,
   localparam int unsigned Share = EnMasking ? 2 : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [2:0]               strength_i,
   input  logic [11:0]              out_len_i,
   input  logic [3:0]               absorbed_i,
   input  logic                     state_valid_i,
   input  logic [Share-1:0][1599:0] state_i,
   input  logic                     block_processed_i,
   output logic                     run_o,
   output logic [3:0]               done_o,
   output logic                     busy_o,
   input  logic [3:0]               lc_escalate_en_i,
   output logic                     error_o,
   sha3_digest_reader_if.master     digest
);

   localparam logic [3:0] MuBi4True  = 4'h6;
   localparam logic [3:0] MuBi4False = 4'h9;
   localparam logic [3:0] LcTxOff    = 4'hA;

   typedef enum logic [5:0] {
      StIdle       = 6'b101100,
      StWaitAbsorb = 6'b010011,
      StEmit       = 6'b111010,
      StRun        = 6'b000101,
      StWaitRun    = 6'b100011,
      StDone       = 6'b011100,
      StError      = 6'b110111
   } state_e;

   state_e      state_q;
   logic [2:0]  strength_q;
   logic [11:0] len_q;
   logic [4:0]  w_q;
   logic [11:0] remaining_q;

   logic [4:0]  rate;
   logic [4:0]  w_inc;
   logic [63:0] word_first;
   logic [63:0] word_next;
   logic        strength_legal;
   logic        to_error;

   assign strength_legal = (strength_i <= 3'd4);

   always_comb begin
      case (strength_q)
         3'd0:    rate = 5'd21;
         3'd1:    rate = 5'd18;
         3'd2:    rate = 5'd17;
         3'd3:    rate = 5'd13;
         default: rate = 5'd9;
      endcase
   end

   // Unmasked words: first word of a block and the word after the current one.
   always_comb begin
      w_inc      = w_q + 5'd1;
      word_first = '0;
      word_next  = '0;
      for (int unsigned s = 0; s < Share; s++) begin
         word_first ^= state_i[s[0]][0 +: 64];
         word_next  ^= state_i[s[0]][{w_inc, 6'd0} +: 64];
      end
   end

   always_comb begin
      to_error = (lc_escalate_en_i != LcTxOff);
      case (state_q)
         StIdle: begin
            if (start_i && (out_len_i == '0 || !strength_legal)) to_error = 1'b1;
         end
         StEmit: begin
            if (!state_valid_i) to_error = 1'b1;
            if (digest.ready && (remaining_q == '0 || w_q == '1)) to_error = 1'b1;
         end
         StWaitAbsorb, StRun, StWaitRun, StDone, StError: ;
         default: to_error = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         strength_q   <= '0;
         len_q        <= '0;
         w_q          <= '0;
         remaining_q  <= '0;
         run_o        <= 1'b0;
         done_o       <= MuBi4False;
         digest.valid <= 1'b0;
         digest.data  <= '0;
         digest.last  <= 1'b0;
         busy_o       <= 1'b0;
         error_o      <= 1'b0;
      end else if (to_error) begin
         state_q      <= StError;
         w_q          <= '0;
         remaining_q  <= '0;
         run_o        <= 1'b0;
         done_o       <= MuBi4False;
         digest.valid <= 1'b0;
         digest.data  <= '0;
         digest.last  <= 1'b0;
         busy_o       <= 1'b1;
         error_o      <= 1'b1;
      end else begin
         if (start_i && state_q != StIdle) error_o <= 1'b1;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  strength_q <= strength_i;
                  len_q      <= out_len_i;
                  state_q    <= StWaitAbsorb;
                  busy_o     <= 1'b1;
               end
            end
            StWaitAbsorb: begin
               if (absorbed_i == MuBi4True && state_valid_i) begin
                  state_q      <= StEmit;
                  w_q          <= '0;
                  remaining_q  <= len_q;
                  digest.valid <= 1'b1;
                  digest.data  <= word_first;
                  digest.last  <= (len_q == 12'd1);
               end
            end
            StEmit: begin
               if (digest.ready) begin
                  remaining_q <= remaining_q - 12'd1;
                  w_q         <= w_inc;
                  // Final word wins over the rate boundary.
                  if (remaining_q == 12'd1) begin
                     state_q      <= StDone;
                     done_o       <= MuBi4True;
                     digest.valid <= 1'b0;
                     digest.data  <= '0;
                     digest.last  <= 1'b0;
                  end else if (w_q == rate - 5'd1) begin
                     state_q      <= StRun;
                     run_o        <= 1'b1;
                     digest.valid <= 1'b0;
                     digest.data  <= '0;
                     digest.last  <= 1'b0;
                  end else begin
                     digest.data <= word_next;
                     digest.last <= (remaining_q == 12'd2);
                  end
               end
            end
            StRun: begin
               run_o   <= 1'b0;
               state_q <= StWaitRun;
            end
            StWaitRun: begin
               if (block_processed_i && state_valid_i) begin
                  state_q      <= StEmit;
                  w_q          <= '0;
                  digest.valid <= 1'b1;
                  digest.data  <= word_first;
                  digest.last  <= (remaining_q == 12'd1);
               end
            end
            StDone: begin
               done_o  <= MuBi4False;
               busy_o  <= 1'b0;
               state_q <= StIdle;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha3_digest_reader.sv
// Bench for sha3_digest_reader: random squeeze jobs; expected words come from
// a queue model indexing the random block states by word number.
module tb_sha3_digest_reader;
   localparam bit          Mask    = 1'b1;
   localparam int unsigned Share   = 2;
   localparam logic [3:0]  MuTrue  = 4'h6;
   localparam logic [3:0]  MuFalse = 4'h9;
   localparam logic [3:0]  LcOff   = 4'hA;
   localparam logic [3:0]  LcOn    = 4'h5;

   typedef logic [1599:0] st_t;
   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } exp_t;

   logic                     clk_i = 1'b0;
   logic                     rst_ni;
   logic                     start_i;
   logic [2:0]               strength_i;
   logic [11:0]              out_len_i;
   logic [3:0]               absorbed_i;
   logic                     state_valid_i;
   logic [Share-1:0][1599:0] state_i;
   logic                     block_processed_i;
   logic                     run_o;
   logic [3:0]               done_o;
   logic                     busy_o;
   logic [3:0]               lc_escalate_en_i;
   logic                     error_o;

   sha3_digest_reader_if dif ();

   always #5 clk_i = ~clk_i;

   sha3_digest_reader #(.EnMasking(Mask)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .start_i           (start_i),
      .strength_i        (strength_i),
      .out_len_i         (out_len_i),
      .absorbed_i        (absorbed_i),
      .state_valid_i     (state_valid_i),
      .state_i           (state_i),
      .block_processed_i (block_processed_i),
      .run_o             (run_o),
      .done_o            (done_o),
      .busy_o            (busy_o),
      .lc_escalate_en_i  (lc_escalate_en_i),
      .error_o           (error_o),
      .digest            (dif)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   st_t  blk_a[$];
   st_t  blk_b[$];
   int   cur_blk, runs_seen, words_seen, done_seen, bp_mode;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic st_t rand_state();
      st_t s;
      for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   function automatic int rate_of(input logic [2:0] str);
      case (str)
         3'd0:    return 21;
         3'd1:    return 18;
         3'd2:    return 17;
         3'd3:    return 13;
         default: return 9;
      endcase
   endfunction

   function automatic logic [63:0] model_word(input int b, input int k);
      st_t a, c;
      a = blk_a[b];
      c = blk_b[b];
      return a[64*k +: 64] ^ c[64*k +: 64];
   endfunction

   // Consumer ready pattern, changed just after each rising edge.
   initial begin
      int cyc;
      cyc = 0;
      dif.ready = 1'b1;
      forever begin
         @(posedge clk_i);
         #2;
         cyc++;
         case (bp_mode)
            0:       dif.ready = 1'b1;
            1:       dif.ready = ($urandom_range(0, 2) != 0);
            2:       dif.ready = (cyc % 4 == 3);
            default: dif.ready = 1'b0;
         endcase
      end
   end

   // Permutation responder: next block state appears with block_processed_i.
   initial begin
      block_processed_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (run_o === 1'b1) begin
            runs_seen++;
            state_valid_i = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk_i);
            #1;
            cur_blk++;
            check("run_within_job", 64'(cur_blk < blk_a.size()), 64'd1);
            if (cur_blk < blk_a.size()) state_i = {blk_b[cur_blk], blk_a[cur_blk]};
            block_processed_i = 1'b1;
            state_valid_i     = 1'b1;
            @(posedge clk_i);
            #1;
            block_processed_i = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake.
   initial begin
      logic        pv, pr, pl, prun;
      logic [63:0] pd;
      logic [3:0]  pdone;
      exp_t        e;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; prun = 1'b0; pd = '0; pdone = MuFalse;
      forever begin
         @(negedge clk_i);
         if (dif.valid === 1'b1) begin
            if (pv && !pr) begin
               check("hold_data", dif.data, pd);
               check("hold_last", 64'(dif.last), 64'(pl));
            end
            if (dif.ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %0h expected no word", dif.data);
               end else begin
                  e = sb.pop_front();
                  check("word_data", dif.data, e.data);
                  check("word_last", 64'(dif.last), 64'(e.last));
               end
               words_seen++;
            end
         end else begin
            check("idle_data_zero", dif.data, 64'd0);
         end
         if (run_o === 1'b1) check("run_one_cycle", 64'(prun), 64'd0);
         if (done_o !== MuFalse) begin
            check("done_value", 64'(done_o), 64'(MuTrue));
            check("done_one_cycle", 64'(pdone), 64'(MuFalse));
            done_seen++;
         end
         pv = dif.valid; pr = dif.ready; pd = dif.data; pl = dif.last;
         prun = run_o; pdone = done_o;
      end
   end

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      check("rst_run", 64'(run_o), 64'd0);
      check("rst_done", 64'(done_o), 64'(MuFalse));
      check("rst_valid", 64'(dif.valid), 64'd0);
      check("rst_data", dif.data, 64'd0);
      check("rst_last", 64'(dif.last), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_error", 64'(error_o), 64'd0);
      start_i          = 1'b0;
      absorbed_i       = MuFalse;
      state_valid_i    = 1'b0;
      lc_escalate_en_i = LcOff;
      bp_mode          = 0;
      sb.delete();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic prep_job(input logic [2:0] str, input int len, input int mode);
      int rate, nblk;
      rate = rate_of(str);
      nblk = (len + rate - 1) / rate;
      blk_a.delete();
      blk_b.delete();
      for (int b = 0; b < nblk; b++) begin
         blk_a.push_back(rand_state());
         blk_b.push_back(rand_state());
      end
      for (int k = 0; k < len; k++)
         sb.push_back('{data: model_word(k / rate, k % rate), last: (k == len - 1)});
      cur_blk = 0; runs_seen = 0; words_seen = 0; done_seen = 0; bp_mode = mode;
      state_i = {blk_b[0], blk_a[0]};
      @(posedge clk_i);
      #1;
      strength_i = str;
      out_len_i  = 12'(len);
      start_i    = 1'b1;
      @(posedge clk_i);
      #1;
      start_i    = 1'b0;
      strength_i = 3'($urandom);
      out_len_i  = 12'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      absorbed_i    = MuTrue;
      state_valid_i = 1'b1;
   endtask

   task automatic run_job(input logic [2:0] str, input int len, input int mode, input bit inj);
      int  nblk;
      bit  timeout;
      nblk = (len + rate_of(str) - 1) / rate_of(str);
      prep_job(str, len, mode);
      if (inj) begin
         @(posedge clk_i);
         #1 start_i = 1'b1;
         @(posedge clk_i);
         #1 start_i = 1'b0;
      end
      timeout = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_i);
         if (done_o === MuTrue) begin
            timeout = 1'b0;
            break;
         end
      end
      check("done_reached", 64'(timeout), 64'd0);
      check("word_count", 64'(words_seen), 64'(len));
      check("run_count", 64'(runs_seen), 64'(nblk - 1));
      check("sb_empty", 64'(sb.size()), 64'd0);
      check("error_flag", 64'(error_o), 64'(inj));
      @(negedge clk_i);
      check("idle_after_done", 64'(busy_o), 64'd0);
      check("done_cleared", 64'(done_o), 64'(MuFalse));
      check("done_pulses", 64'(done_seen), 64'd1);
      absorbed_i    = MuFalse;
      state_valid_i = 1'b0;
   endtask

   task automatic bad_start(input logic [2:0] str, input logic [11:0] len);
      done_seen = 0;
      @(posedge clk_i);
      #1;
      strength_i = str;
      out_len_i  = len;
      start_i    = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (5) @(negedge clk_i);
      check("bad_error", 64'(error_o), 64'd1);
      check("bad_busy", 64'(busy_o), 64'd1);
      check("bad_no_done", 64'(done_seen), 64'd0);
      check("bad_valid", 64'(dif.valid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst_ni = 1'b1; start_i = 1'b0; strength_i = '0; out_len_i = '0;
      absorbed_i = MuFalse; state_valid_i = 1'b0; state_i = '0;
      lc_escalate_en_i = LcOff; bp_mode = 0;
      cur_blk = 0; runs_seen = 0; words_seen = 0; done_seen = 0;
      #2;
      do_reset();

      run_job(3'd2, 4, 0, 1'b0);
      run_job(3'd4, 20, 0, 1'b0);
      run_job(3'd2, 17, 1, 1'b0);
      run_job(3'd0, 30, 2, 1'b0);
      run_job(3'd1, 12, 1, 1'b1);
      do_reset();
      for (int j = 0; j < 6; j++)
         run_job(3'($urandom_range(0, 4)), $urandom_range(1, 45), $urandom_range(0, 2), 1'b0);

      bad_start(3'd2, 12'd0);
      do_reset();
      bad_start(3'd6, 12'd5);
      do_reset();

      prep_job(3'd4, 20, 3);
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_i);
         if (dif.valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("esc_emit_reached", 64'(found), 64'd1);
      @(posedge clk_i);
      #1 lc_escalate_en_i = LcOn;
      @(posedge clk_i);
      @(negedge clk_i);
      check("esc_valid", 64'(dif.valid), 64'd0);
      check("esc_data", dif.data, 64'd0);
      check("esc_error", 64'(error_o), 64'd1);
      check("esc_busy", 64'(busy_o), 64'd1);
      check("esc_run", 64'(run_o), 64'd0);
      check("esc_done", 64'(done_o), 64'(MuFalse));
      lc_escalate_en_i = LcOff;
      repeat (3) @(negedge clk_i);
      check("err_terminal", 64'(error_o), 64'd1);
      check("err_no_valid", 64'(dif.valid), 64'd0);
      do_reset();
      repeat (3) @(negedge clk_i);
      check("post_reset_idle", 64'(busy_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
